// File: rtl/axi_pkg.sv
// Shared AXI constants, FSM state encoding and the beat-size helper
// used by the burst master.
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WDATA = 3'd2,
    S_WRESP = 3'd3,
    S_RADDR = 3'd4,
    S_RDATA = 3'd5
  } state_t;

  function automatic logic [2:0] axi_size(input int strb_width);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 1; i < 8; i++)
      if ((1 << i) <= strb_width) s = 3'(i);
    return s;
  endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 bus bundle between the burst master and the RAM slave.
// Only the channels and fields the burst master drives are carried.
interface axi_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic [7:0]            m_awlen;
  logic [2:0]            m_awsize;
  logic [1:0]            m_awburst;
  logic                  m_awvalid;
  logic                  m_awready;

  logic [DATA_WIDTH-1:0] m_wdata;
  logic [STRB_WIDTH-1:0] m_wstrb;
  logic                  m_wlast;
  logic                  m_wvalid;
  logic                  m_wready;

  logic [1:0]            m_bresp;
  logic                  m_bvalid;
  logic                  m_bready;

  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;
  logic                  m_arvalid;
  logic                  m_arready;

  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rlast;
  logic                  m_rvalid;
  logic                  m_rready;

  modport master (
    output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready,
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_rready
  );

  modport slave (
    input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready,
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_rready
  );

endinterface

// File: rtl/axi_burst_master.sv
// Turns single write/read commands into one AXI4 INCR burst each,
// streaming W beats in and R beats out without local buffering.
module axi_burst_master
  import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  Reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,

    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,

    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,

    output logic                  done,
    output logic                  err,

    axi_burst_master_if.master    m
);

  localparam logic [2:0] AXI_SIZE = axi_size(STRB_WIDTH);

  state_t                state_q;
  state_t                state_d;
  logic                  alive_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic                  err_acc;
  logic                  awvalid_q;
  logic                  arvalid_q;
  logic                  bready_q;

  logic cmd_hs;
  logic aw_hs;
  logic ar_hs;
  logic w_hs;
  logic b_hs;
  logic r_hs;
  logic at_last;
  logic r_bad;

  assign cmd_ready = alive_q && (state_q == S_IDLE);
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign aw_hs     = awvalid_q && m.m_awready;
  assign ar_hs     = arvalid_q && m.m_arready;
  assign w_hs      = (state_q == S_WDATA) && wr_valid && m.m_wready;
  assign b_hs      = bready_q && m.m_bvalid;
  assign r_hs      = (state_q == S_RDATA) && m.m_rvalid && rd_ready;
  assign at_last   = (beat_cnt == len_q);
  assign r_bad     = (m.m_rresp != RESP_OKAY) || (m.m_rlast && !at_last);

  assign m.m_awaddr  = addr_q;
  assign m.m_awlen   = len_q;
  assign m.m_awsize  = AXI_SIZE;
  assign m.m_awburst = BURST_INCR;
  assign m.m_awvalid = awvalid_q;

  assign m.m_araddr  = addr_q;
  assign m.m_arlen   = len_q;
  assign m.m_arsize  = AXI_SIZE;
  assign m.m_arburst = BURST_INCR;
  assign m.m_arvalid = arvalid_q;

  // W and R are pure passthroughs gated by the owning state.
  assign m.m_wdata  = wr_data;
  assign m.m_wstrb  = '1;
  assign m.m_wvalid = (state_q == S_WDATA) && wr_valid;
  assign m.m_wlast  = (state_q == S_WDATA) && at_last;
  assign wr_ready   = (state_q == S_WDATA) && m.m_wready;
  assign m.m_bready = bready_q;

  assign rd_data    = m.m_rdata;
  assign rd_valid   = (state_q == S_RDATA) && m.m_rvalid;
  assign rd_last    = (state_q == S_RDATA) && m.m_rlast;
  assign m.m_rready = (state_q == S_RDATA) && rd_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_hs) state_d = cmd_write ? S_WADDR : S_RADDR;
      S_WADDR: if (aw_hs) state_d = S_WDATA;
      S_WDATA: if (w_hs && at_last) state_d = S_WRESP;
      S_WRESP: if (b_hs) state_d = S_IDLE;
      S_RADDR: if (ar_hs) state_d = S_RDATA;
      S_RDATA: if (r_hs && m.m_rlast) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      alive_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      err_acc   <= 1'b0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      if (cmd_hs) begin
        addr_q    <= cmd_addr;
        len_q     <= cmd_len;
        beat_cnt  <= '0;
        err_acc   <= 1'b0;
        awvalid_q <= cmd_write;
        arvalid_q <= !cmd_write;
      end
      if (aw_hs) awvalid_q <= 1'b0;
      if (ar_hs) arvalid_q <= 1'b0;
      if (w_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (at_last) bready_q <= 1'b1;
      end
      if (b_hs) begin
        bready_q <= 1'b0;
        done     <= 1'b1;
        err      <= err_acc || (m.m_bresp != RESP_OKAY);
      end
      // Overlong bursts keep streaming; the count mismatch is flagged at rlast.
      if (r_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        err_acc  <= err_acc || r_bad;
        if (m.m_rlast) begin
          done <= 1'b1;
          err  <= err_acc || r_bad;
        end
      end
    end
  end

endmodule
